// File: rtl/key_move_scheduler.sv
// Move-command scheduler between the key debouncer and the 2048 engine:
// tick-sampled press detection, fixed-priority arbitration, valid/ready issue, auto-repeat.
module key_move_scheduler #(
    parameter int TICK_W       = 8,
    parameter int REPEAT_TICKS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] keyin,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    input  logic       move_done,
    output logic       busy,
    output logic       dropped
);
    localparam int            RW       = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
    localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_TICKS);
    localparam logic [RW-1:0] REP_FIRE = RW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
    localparam bit            REP_EN   = (REPEAT_TICKS != 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t            state_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [4:0]        key_q;
    logic              pending_q;
    logic [RW-1:0]     rep_cnt_q;
    logic [1:0]        last_dir_q;
    logic              rep_arm_q;
    logic              cmd_valid_q;
    logic [2:0]        cmd_q;
    logic              busy_q;

    logic       tick;
    logic [4:0] press;
    logic [2:0] win_cmd;
    logic [3:0] win_dir;
    logic       rep_hold;
    logic       rep_fire;
    logic       rep_inc;
    logic       issue_d;
    logic [2:0] cmd_d;
    logic [3:0] drop_mask;

    assign tick     = &tick_cnt_q;
    assign press    = tick ? (keyin & ~key_q) : 5'b00000;
    assign rep_hold = keyin[last_dir_q];
    // The counter fires on the tick that would bring it to REPEAT_TICKS.
    assign rep_fire = REP_EN && rep_arm_q && tick && rep_hold && (rep_cnt_q == REP_FIRE);

    always_comb begin
        win_cmd = 3'd0;
        win_dir = 4'b0000;
        if (press[4]) begin
            win_cmd = 3'd4;
        end else if (press[0]) begin
            win_cmd = 3'd0;
            win_dir = 4'b0001;
        end else if (press[1]) begin
            win_cmd = 3'd1;
            win_dir = 4'b0010;
        end else if (press[2]) begin
            win_cmd = 3'd2;
            win_dir = 4'b0100;
        end else if (press[3]) begin
            win_cmd = 3'd3;
            win_dir = 4'b1000;
        end
    end

    always_comb begin
        issue_d   = 1'b0;
        cmd_d     = 3'd0;
        drop_mask = press[3:0];
        if (state_q == IDLE) begin
            if (pending_q) begin
                issue_d = 1'b1;
                cmd_d   = 3'd4;
            end else if (|press) begin
                issue_d   = 1'b1;
                cmd_d     = win_cmd;
                drop_mask = press[3:0] & ~win_dir;
            end else if (rep_fire) begin
                issue_d = 1'b1;
                cmd_d   = {1'b0, last_dir_q};
            end
        end
    end

    assign rep_inc = REP_EN && (state_q == IDLE) && !issue_d && tick && rep_hold
                     && rep_arm_q && (rep_cnt_q != REP_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            key_q       <= 5'b11111;
            pending_q   <= 1'b0;
            rep_cnt_q   <= '0;
            last_dir_q  <= 2'd0;
            rep_arm_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= 3'd0;
            busy_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            if (tick) key_q <= keyin;

            if (tick && !rep_hold) rep_cnt_q <= '0;
            else if (rep_inc)      rep_cnt_q <= rep_cnt_q + RW'(1);

            case (state_q)
                IDLE: begin
                    if (issue_d) begin
                        state_q     <= ISSUE;
                        cmd_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        cmd_q       <= cmd_d;
                        pending_q   <= 1'b0;
                        rep_cnt_q   <= '0;
                        // Restart disarms repeat so it can never be re-issued.
                        rep_arm_q   <= !cmd_d[2];
                        if (!cmd_d[2]) last_dir_q <= cmd_d[1:0];
                    end
                end
                ISSUE: begin
                    if (press[4]) pending_q <= 1'b1;
                    if (cmd_ready) begin
                        state_q     <= WAIT_DONE;
                        cmd_valid_q <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (press[4]) pending_q <= 1'b1;
                    if (move_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign busy      = busy_q;
    assign dropped   = |drop_mask;

endmodule

// File: tb/tb_key_move_scheduler.sv
// Directed bench for key_move_scheduler (TICK_W=2, REPEAT_TICKS=3): cycle table plus
// hand sequences for restart collapsing, auto-repeat and reset during ISSUE.
module tb_key_move_scheduler;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] keyin;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic       move_done;
    logic       busy;
    logic       dropped;

    int checks = 0;
    int errors = 0;
    int gcyc   = 0;
    int acc_cyc[$];
    int acc_cmd[$];

    key_move_scheduler #(.TICK_W(2), .REPEAT_TICKS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .keyin     (keyin),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .move_done (move_done),
        .busy      (busy),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    // Record every accepted command with the cycle it was accepted in.
    always @(posedge clk) begin
        gcyc <= gcyc + 1;
        if (rst && cmd_valid && cmd_ready) begin
            acc_cyc.push_back(gcyc);
            acc_cmd.push_back(int'(cmd));
        end
    end

    typedef struct {
        int         n;
        logic [4:0] key;
        logic       rdy;
        logic       done;
        logic       ev;
        logic [2:0] ec;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [4:0] k, input logic r, input logic d);
        @(negedge clk);
        keyin     = k;
        cmd_ready = r;
        move_done = d;
        #1;
    endtask

    task automatic run_until_valid(input logic [4:0] k, input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            step(k, 1'b0, 1'b0);
            if (cmd_valid) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit seen;
        int n0;
        int nres;
        int bad;

        // n, key, rdy, done -> valid, cmd, busy, dropped (one entry per run of cycles)
        tbl[0]  = '{20, 5'b00001, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{ 4, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{ 3, 5'b00001, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{ 2, 5'b00001, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0};
        tbl[4]  = '{ 1, 5'b00001, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0};
        tbl[5]  = '{ 3, 5'b00001, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[6]  = '{ 1, 5'b00010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[7]  = '{ 1, 5'b00010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
        tbl[8]  = '{ 1, 5'b00010, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[9]  = '{16, 5'b00010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{ 3, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[11] = '{ 3, 5'b01100, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[12] = '{ 1, 5'b01100, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[13] = '{ 1, 5'b01100, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0};
        tbl[14] = '{ 1, 5'b01100, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0};
        tbl[15] = '{ 5, 5'b00000, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};

        rst       = 1'b0;
        keyin     = 5'b00001;
        cmd_ready = 1'b0;
        move_done = 1'b0;

        @(negedge clk);
        chk("reset_valid", int'(cmd_valid), 0);
        chk("reset_cmd", int'(cmd), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_dropped", int'(dropped), 0);
        @(negedge clk);
        #2 rst = 1'b1;

        // Held-through-reset key, up press/accept/done, drop in WAIT_DONE, left+right arbitration.
        for (int v = 0; v < 16; v++) begin
            for (int c = 0; c < tbl[v].n; c++) begin
                step(tbl[v].key, tbl[v].rdy, tbl[v].done);
                chk($sformatf("tbl%0d_c%0d_valid", v, c), int'(cmd_valid), int'(tbl[v].ev));
                chk($sformatf("tbl%0d_c%0d_cmd", v, c), int'(cmd), int'(tbl[v].ec));
                chk($sformatf("tbl%0d_c%0d_busy", v, c), int'(busy), int'(tbl[v].eb));
                chk($sformatf("tbl%0d_c%0d_dropped", v, c), int'(dropped), int'(tbl[v].ed));
            end
        end

        // Restart pressed twice while waiting collapses into one immediate restart.
        n0 = acc_cmd.size();
        run_until_valid(5'b00001, 12, seen);
        chk("s4_up_issued", int'(seen), 1);
        chk("s4_up_cmd", int'(cmd), 0);
        step(5'b00001, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step((i >= 4 && i < 8) ? 5'b00000 : 5'b10000, 1'b0, 1'b0);
            chk($sformatf("s4_wait%0d_busy", i), int'(busy), 1);
            chk($sformatf("s4_wait%0d_valid", i), int'(cmd_valid), 0);
            chk($sformatf("s4_wait%0d_dropped", i), int'(dropped), 0);
        end
        step(5'b10000, 1'b0, 1'b1);
        chk("s4_done_busy", int'(busy), 1);
        step(5'b10000, 1'b0, 1'b0);
        chk("s4_idle_busy", int'(busy), 0);
        chk("s4_idle_valid", int'(cmd_valid), 0);
        step(5'b10000, 1'b0, 1'b0);
        chk("s4_restart_valid", int'(cmd_valid), 1);
        chk("s4_restart_cmd", int'(cmd), 4);
        chk("s4_restart_busy", int'(busy), 1);
        step(5'b10000, 1'b1, 1'b0);
        step(5'b00000, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(5'b00000, 1'b1, 1'b0);
        nres = 0;
        for (int i = n0; i < acc_cmd.size(); i++) if (acc_cmd[i] == 4) nres++;
        chk("s4_restart_count", nres, 1);
        chk("s4_total_accepts", acc_cmd.size() - n0, 2);

        // Held right with an always-ready engine repeats every 3 ticks (12 cycles).
        n0 = acc_cmd.size();
        for (int i = 0; i < 80; i++) begin
            step(5'b01000, 1'b1, 1'b1);
            if (acc_cmd.size() - n0 >= 4) break;
        end
        chk("s5_accepts", acc_cmd.size() - n0, 4);
        if (acc_cmd.size() - n0 >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("s5_cmd%0d", k), acc_cmd[n0 + k], 3);
                if (k > 0) chk($sformatf("s5_gap%0d", k), acc_cyc[n0 + k] - acc_cyc[n0 + k - 1], 12);
            end
        end
        n0 = acc_cmd.size();
        for (int i = 0; i < 30; i++) step(5'b00000, 1'b1, 1'b1);
        chk("s5_after_release", acc_cmd.size() - n0, 0);

        // Stalled engine holds the command; reset mid-ISSUE drops it immediately.
        for (int i = 0; i < 4; i++) step(5'b00000, 1'b0, 1'b0);
        run_until_valid(5'b00010, 12, seen);
        chk("s6_issued", int'(seen), 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(5'b00010, 1'b0, 1'b0);
            if (!cmd_valid || cmd != 3'd1) bad++;
        end
        chk("s6_stall_stable_bad_cycles", bad, 0);
        chk("s6_stall_cmd", int'(cmd), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("s6_rst_valid", int'(cmd_valid), 0);
        chk("s6_rst_busy", int'(busy), 0);
        chk("s6_rst_cmd", int'(cmd), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step(5'b00010, 1'b1, 1'b0);
            if (cmd_valid || busy) bad++;
        end
        chk("s6_post_reset_idle_bad_cycles", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
